// File: rtl/reg_write_arbiter.sv
// Round-robin owner of the register-file write port shared by N_REQ write-back requesters.
// After reset, it clears R1..R(2**ADDR_W-1) one register per cycle before arbitration starts.
module reg_write_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [N_REQ-1:0]          Req,
  input  logic [N_REQ*ADDR_W-1:0]   Req_Reg,
  input  logic [N_REQ*DATA_W-1:0]   Req_Data,
  output logic [N_REQ-1:0]          Grant,
  output logic                      Init_Done,
  output logic                      Reg_Write,
  output logic [ADDR_W-1:0]         Write_Reg,
  output logic [DATA_W-1:0]         Write_Data
);

  // state | meaning
  // INIT  | clearing R1..R(2**ADDR_W-1), one register per cycle; requests held off
  // RUN   | round-robin arbitration of write-back requests, one write per cycle

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    next_ptr;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [ADDR_W-1:0]   sel_reg;
  logic [DATA_W-1:0]   sel_data;
  logic [2*N_REQ-1:0]  req_dbl;
  logic [N_REQ-1:0]    req_rot;
  logic                found;
  logic                arb_en;

  // Rotate the request vector so bit 0 is the requester at rr_ptr, then take the first set bit.
  always_comb begin
    int sum;
    sum       = 0;
    found     = 1'b0;
    grant_idx = '0;
    req_dbl   = {Req, Req} >> rr_ptr;
    req_rot   = req_dbl[N_REQ-1:0];
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        sum   = int'(rr_ptr) + k;
        if (sum >= N_REQ) sum = sum - N_REQ;
        grant_idx = PTR_W'(sum);
      end
    end
  end

  assign arb_en   = Rst_n && (state == RUN);
  assign Grant    = (arb_en && found) ? (N_REQ'(1) << grant_idx) : '0;
  assign sel_reg  = Req_Reg[grant_idx*ADDR_W +: ADDR_W];
  assign sel_data = Req_Data[grant_idx*DATA_W +: DATA_W];
  assign next_ptr = (grant_idx == PTR_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state      <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
      Reg_Write  <= 1'b0;
      Write_Reg  <= '0;
      Write_Data <= '0;
      Init_Done  <= 1'b0;
      rr_ptr     <= '0;
      clr_cnt    <= ADDR_W'(1);
    end else begin
      case (state)
        INIT: begin
          Reg_Write  <= 1'b1;
          Write_Reg  <= clr_cnt;
          Write_Data <= '0;
          clr_cnt    <= clr_cnt + 1'b1;
          if (clr_cnt == {ADDR_W{1'b1}}) begin
            state     <= RUN;
            Init_Done <= 1'b1;
          end
        end
        RUN: begin
          Init_Done <= 1'b1;
          if (found) begin
            // R0 is hard-wired zero: the request is consumed but never written.
            Reg_Write  <= (sel_reg != '0);
            Write_Reg  <= sel_reg;
            Write_Data <= sel_data;
            rr_ptr     <= next_ptr;
          end else begin
            Reg_Write  <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: clear sweep, round-robin order, R0 rule and reset abort.
// A small register-file model driven by the write port checks what actually gets committed.
module tb_reg_write_arbiter;
  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            Clk = 1'b0;
  logic            Rst_n;
  logic [N-1:0]    Req;
  logic [N*AW-1:0] Req_Reg;
  logic [N*DW-1:0] Req_Data;
  logic [N-1:0]    Grant;
  logic            Init_Done;
  logic            Reg_Write;
  logic [AW-1:0]   Write_Reg;
  logic [DW-1:0]   Write_Data;

  logic [DW-1:0]   rf [0:31];
  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  reg_write_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Req_Reg(Req_Reg), .Req_Data(Req_Data),
    .Grant(Grant), .Init_Done(Init_Done), .Reg_Write(Reg_Write),
    .Write_Reg(Write_Reg), .Write_Data(Write_Data)
  );

  always @(posedge Clk) if (Reg_Write) rf[Write_Reg] <= Write_Data;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
    Req_Reg[i*AW +: AW]  = r;
    Req_Data[i*DW +: DW] = d;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0; Req = 4'b1111; Req_Reg = '0; Req_Data = '0;
    tick; tick; #1;
    checks++; if (Grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", Grant); end
    checks++; if (Reg_Write !== 1'b0) begin errors++; $display("FAIL reset_reg_write got %b want 0", Reg_Write); end
    checks++; if (Write_Reg !== 5'd0) begin errors++; $display("FAIL reset_write_reg got %0d want 0", Write_Reg); end
    checks++; if (Write_Data !== 32'd0) begin errors++; $display("FAIL reset_write_data got %h want 0", Write_Data); end
    checks++; if (Init_Done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", Init_Done); end
  endtask

  task automatic test_init_sweep;
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), 32'hA000_0000 + i);
    Req = 4'b1111;
    Rst_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      #1;
      checks++; if (Grant !== 4'b0000) begin errors++; $display("FAIL sweep_grant k=%0d got %b want 0000", k, Grant); end
      checks++; if (Init_Done !== 1'b0) begin errors++; $display("FAIL sweep_init_done k=%0d got %b want 0", k, Init_Done); end
      tick;
      checks++; if (Reg_Write !== 1'b1) begin errors++; $display("FAIL sweep_reg_write k=%0d got %b want 1", k, Reg_Write); end
      checks++; if (Write_Reg !== AW'(k)) begin errors++; $display("FAIL sweep_write_reg got %0d want %0d", Write_Reg, k); end
      checks++; if (Write_Data !== 32'd0) begin errors++; $display("FAIL sweep_write_data k=%0d got %h want 0", k, Write_Data); end
    end
    #1;
    checks++; if (Init_Done !== 1'b1) begin errors++; $display("FAIL sweep_init_done_end got %b want 1", Init_Done); end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] exp_g;
    for (int c = 0; c < 8; c++) begin
      exp_g = 4'b0001 << (c % 4);
      #1;
      checks++; if (Grant !== exp_g) begin errors++; $display("FAIL rr_grant c=%0d got %b want %b", c, Grant, exp_g); end
      tick;
      checks++; if (Reg_Write !== 1'b1) begin errors++; $display("FAIL rr_reg_write c=%0d got %b want 1", c, Reg_Write); end
      checks++; if (Write_Reg !== AW'(c % 4 + 1)) begin errors++; $display("FAIL rr_write_reg c=%0d got %0d want %0d", c, Write_Reg, c % 4 + 1); end
      checks++; if (Write_Data !== 32'hA000_0000 + (c % 4)) begin errors++; $display("FAIL rr_write_data c=%0d got %h want %h", c, Write_Data, 32'hA000_0000 + (c % 4)); end
    end
    Req = '0;
    tick;
    checks++; if (Reg_Write !== 1'b0) begin errors++; $display("FAIL idle_reg_write got %b want 0", Reg_Write); end
    for (int r = 1; r <= 4; r++) begin
      checks++; if (rf[r] !== 32'hA000_0000 + (r - 1)) begin errors++; $display("FAIL rf_rr R%0d got %h want %h", r, rf[r], 32'hA000_0000 + (r - 1)); end
    end
    for (int r = 5; r <= 31; r++) begin
      checks++; if (rf[r] !== 32'd0) begin errors++; $display("FAIL rf_clear R%0d got %h want 0", r, rf[r]); end
    end
  endtask

  task automatic test_single;
    set_req(2, 5'd7, 32'hDEAD_BEEF);
    Req = 4'b0100;
    #1;
    checks++; if (Grant !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", Grant); end
    tick;
    Req = '0;
    checks++; if (Reg_Write !== 1'b1) begin errors++; $display("FAIL single_reg_write got %b want 1", Reg_Write); end
    checks++; if (Write_Reg !== 5'd7) begin errors++; $display("FAIL single_write_reg got %0d want 7", Write_Reg); end
    checks++; if (Write_Data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_write_data got %h want deadbeef", Write_Data); end
    tick;
    checks++; if (Reg_Write !== 1'b0) begin errors++; $display("FAIL hold_reg_write got %b want 0", Reg_Write); end
    checks++; if (Write_Reg !== 5'd7) begin errors++; $display("FAIL hold_write_reg got %0d want 7", Write_Reg); end
    checks++; if (Write_Data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hold_write_data got %h want deadbeef", Write_Data); end
    checks++; if (rf[7] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rf7 got %h want deadbeef", rf[7]); end
  endtask

  task automatic test_r0;
    set_req(0, 5'd0, 32'h0000_1234);
    Req = 4'b0001;
    #1;
    checks++; if (Grant !== 4'b0001) begin errors++; $display("FAIL r0_grant got %b want 0001", Grant); end
    tick;
    Req = '0;
    checks++; if (Reg_Write !== 1'b0) begin errors++; $display("FAIL r0_reg_write got %b want 0", Reg_Write); end
    checks++; if (Write_Data !== 32'h0000_1234) begin errors++; $display("FAIL r0_write_data got %h want 00001234", Write_Data); end
    tick;
    checks++; if (rf[0] !== 32'd0) begin errors++; $display("FAIL r0_rf got %h want 0", rf[0]); end
  endtask

  task automatic test_wrap;
    set_req(1, 5'd11, 32'h11);
    Req = 4'b0010;
    #1;
    checks++; if (Grant !== 4'b0010) begin errors++; $display("FAIL wrap_pre_grant got %b want 0010", Grant); end
    tick;
    set_req(1, 5'd12, 32'h12);
    set_req(3, 5'd13, 32'h13);
    Req = 4'b1010;
    #1;
    checks++; if (Grant !== 4'b1000) begin errors++; $display("FAIL wrap_grant1 got %b want 1000", Grant); end
    tick;
    checks++; if (Write_Reg !== 5'd13) begin errors++; $display("FAIL wrap_write_reg1 got %0d want 13", Write_Reg); end
    Req = 4'b0010;
    #1;
    checks++; if (Grant !== 4'b0010) begin errors++; $display("FAIL wrap_grant2 got %b want 0010", Grant); end
    tick;
    Req = '0;
    checks++; if (Write_Reg !== 5'd12) begin errors++; $display("FAIL wrap_write_reg2 got %0d want 12", Write_Reg); end
    checks++; if (Write_Data !== 32'h12) begin errors++; $display("FAIL wrap_write_data2 got %h want 12", Write_Data); end
  endtask

  task automatic test_back_to_back;
    for (int b = 0; b < 3; b++) begin
      set_req(2, AW'(20 + b), 32'hB0 + b);
      Req = 4'b0100;
      #1;
      checks++; if (Grant !== 4'b0100) begin errors++; $display("FAIL b2b_grant b=%0d got %b want 0100", b, Grant); end
      tick;
      checks++; if (Reg_Write !== 1'b1) begin errors++; $display("FAIL b2b_reg_write b=%0d got %b want 1", b, Reg_Write); end
      checks++; if (Write_Reg !== AW'(20 + b)) begin errors++; $display("FAIL b2b_write_reg got %0d want %0d", Write_Reg, 20 + b); end
      checks++; if (Write_Data !== 32'hB0 + b) begin errors++; $display("FAIL b2b_write_data got %h want %h", Write_Data, 32'hB0 + b); end
    end
    Req = '0;
  endtask

  task automatic test_same_reg;
    set_req(0, 5'd9, 32'd111);
    set_req(1, 5'd9, 32'd222);
    Req = 4'b0011;
    #1;
    checks++; if (Grant !== 4'b0001) begin errors++; $display("FAIL same_grant1 got %b want 0001", Grant); end
    tick;
    Req = 4'b0010;
    #1;
    checks++; if (Grant !== 4'b0010) begin errors++; $display("FAIL same_grant2 got %b want 0010", Grant); end
    tick;
    Req = '0;
    checks++; if (Write_Data !== 32'd222) begin errors++; $display("FAIL same_write_data got %0d want 222", Write_Data); end
    tick;
    checks++; if (rf[9] !== 32'd222) begin errors++; $display("FAIL same_rf9 got %0d want 222", rf[9]); end
  endtask

  task automatic test_reset_mid_sweep;
    Req = 4'b1111;
    Rst_n = 1'b0;
    tick;
    Rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) tick;
    checks++; if (Write_Reg !== 5'd10) begin errors++; $display("FAIL mid_sweep_pos got %0d want 10", Write_Reg); end
    Rst_n = 1'b0;
    #1;
    checks++; if (Grant !== 4'b0000) begin errors++; $display("FAIL mid_rst_grant got %b want 0000", Grant); end
    tick;
    checks++; if (Reg_Write !== 1'b0) begin errors++; $display("FAIL mid_rst_reg_write got %b want 0", Reg_Write); end
    checks++; if (Write_Reg !== 5'd0) begin errors++; $display("FAIL mid_rst_write_reg got %0d want 0", Write_Reg); end
    checks++; if (Init_Done !== 1'b0) begin errors++; $display("FAIL mid_rst_init_done got %b want 0", Init_Done); end
    Rst_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      #1;
      checks++; if (Init_Done !== 1'b0) begin errors++; $display("FAIL resweep_init_done k=%0d got %b want 0", k, Init_Done); end
      checks++; if (Grant !== 4'b0000) begin errors++; $display("FAIL resweep_grant k=%0d got %b want 0000", k, Grant); end
      tick;
      checks++; if (Write_Reg !== AW'(k)) begin errors++; $display("FAIL resweep_write_reg got %0d want %0d", Write_Reg, k); end
    end
    #1;
    checks++; if (Init_Done !== 1'b1) begin errors++; $display("FAIL resweep_init_done_end got %b want 1", Init_Done); end
    Req = '0;
    tick;
  endtask

  initial begin
    rf[0] <= '0;
    for (int r = 1; r < 32; r++) rf[r] <= 32'hFFFF_0000 | r;
    test_reset;
    test_init_sweep;
    test_round_robin;
    test_single;
    test_r0;
    test_wrap;
    test_back_to_back;
    test_same_reg;
    test_reset_mid_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
